command_scheduler: RTL

Sequences sensor transactions for the UART command path. It pairs the received byte stream into {address, command} requests and queues them in a small FIFO. It dispatches one request at a time to the sensor interface with a timeout, then drives the transmitter with a two-byte reply. It sits between the byte receiver and the sensor/transmitter blocks and is the only master of both.

---
 rtl/command_scheduler.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/command_scheduler.sv
// command_scheduler
//   Turns the received UART byte stream into {address, command} pairs, queues
//   them in a small request FIFO and serves them one at a time: each valid
//   request is dispatched to the sensor interface under a timeout, and every
//   request (valid, failed, timed out or invalid) is answered with a two-byte
//   reply on the transmitter.
//
// Ports
//   clk_115200hz   sole clock, rising edge
//   reset          synchronous, active-high
//   rx_data/rx_valid                      received byte and its one-cycle strobe
//   sensor_addr/sensor_cmd/sensor_start   request in flight and its dispatch pulse
//   sensor_done/sensor_error/sensor_result  completion strobe with status and data
//   tx_data/tx_start/tx_busy              reply byte, transmit pulse, transmitter busy
//   overflow       one-cycle pulse when a completed pair is dropped (FIFO full)
//   busy           high unless the FSM is idle and the FIFO is empty
module command_scheduler #(
  parameter int         DEPTH          = 4,
  parameter int         ADDR_MAX       = 31,
  parameter logic [7:0] CMD_MAX        = 8'h07,
  parameter int         PAIR_TIMEOUT   = 2304,
  parameter int         SENSOR_TIMEOUT = 57600
) (
  input  logic       clk_115200hz,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] sensor_addr,
  output logic [7:0] sensor_cmd,
  output logic       sensor_start,
  input  logic       sensor_done,
  input  logic       sensor_error,
  input  logic [7:0] sensor_result,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       overflow,
  output logic       busy
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PCNT_W = $clog2(PAIR_TIMEOUT + 1);
  localparam int TCNT_W = $clog2(SENSOR_TIMEOUT + 1);

  localparam logic [2:0] ST_OK  = 3'b000;
  localparam logic [2:0] ST_ERR = 3'b001;
  localparam logic [2:0] ST_TMO = 3'b010;
  localparam logic [2:0] ST_INV = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_REPLY1, S_TXW1, S_REPLY2, S_TXW2
  } state_t;

  // ---------------------------------------------------------------------------
  // Stage p0: pairing of address byte with the following command byte
  // ---------------------------------------------------------------------------
  logic              have_addr_p0;
  logic [7:0]        addr_p0;
  logic [PCNT_W-1:0] pair_cnt_p0;

  logic push_req;
  logic push_inv;
  logic push;
  logic full;
  logic pop;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [13:0]      mem [DEPTH];
  logic [13:0]      head;

  always_comb begin
    push_req = have_addr_p0 && rx_valid;
    push_inv = (int'(addr_p0) > ADDR_MAX) || (rx_data == 8'd0) || (rx_data > CMD_MAX);
    full     = (count == CNT_W'(DEPTH));
    push     = push_req && !full;
    head     = mem[rd_ptr];
  end

  always_ff @(posedge clk_115200hz) begin
    if (reset) begin
      have_addr_p0 <= 1'b0;
      pair_cnt_p0  <= '0;
    end else if (rx_valid) begin
      if (have_addr_p0) begin
        have_addr_p0 <= 1'b0;
      end else begin
        have_addr_p0 <= 1'b1;
        pair_cnt_p0  <= '0;
      end
    end else if (have_addr_p0) begin
      // The last idle cycle that brings the count to PAIR_TIMEOUT drops the address.
      if (pair_cnt_p0 == PCNT_W'(PAIR_TIMEOUT - 1)) begin
        have_addr_p0 <= 1'b0;
      end else begin
        pair_cnt_p0 <= pair_cnt_p0 + PCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_115200hz) begin
    if (rx_valid && !have_addr_p0) begin
      addr_p0 <= rx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: request FIFO {invalid, addr[4:0], cmd[7:0]}
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_115200hz) begin
    if (push) begin
      mem[wr_ptr] <= {push_inv, addr_p0[4:0], rx_data};
    end
  end

  always_ff @(posedge clk_115200hz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: scheduler FSM, sensor dispatch and reply transmission
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_d;
  logic [TCNT_W-1:0] tmo_cnt;
  logic              tx_guard;
  logic [4:0]        inf_addr;
  logic [7:0]        inf_cmd;
  logic [2:0]        status;
  logic [7:0]        result;

  logic       start_d;
  logic       tx_go;
  logic [7:0] tx_byte;
  logic       cap_done;
  logic       cap_tmo;
  logic       tmo_inc;

  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    start_d  = 1'b0;
    tx_go    = 1'b0;
    tx_byte  = 8'd0;
    cap_done = 1'b0;
    cap_tmo  = 1'b0;
    tmo_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (head[13]) begin
            state_d = S_REPLY1;
          end else begin
            start_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // A completion in the same cycle as the timeout wins.
        if (sensor_done) begin
          cap_done = 1'b1;
          state_d  = S_REPLY1;
        end else if (tmo_cnt == TCNT_W'(SENSOR_TIMEOUT)) begin
          cap_tmo = 1'b1;
          state_d = S_REPLY1;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_REPLY1: begin
        if (!tx_busy) begin
          tx_go   = 1'b1;
          tx_byte = {status, inf_addr};
          state_d = S_TXW1;
        end
      end
      // tx_guard masks the cycle before the transmitter can raise tx_busy.
      S_TXW1: if (!tx_guard && !tx_busy) state_d = S_REPLY2;
      S_REPLY2: begin
        if (!tx_busy) begin
          tx_go   = 1'b1;
          tx_byte = (status == ST_OK) ? result : inf_cmd;
          state_d = S_TXW2;
        end
      end
      S_TXW2: if (!tx_guard && !tx_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_115200hz) begin
    if (reset) begin
      state        <= S_IDLE;
      sensor_start <= 1'b0;
      tx_start     <= 1'b0;
      overflow     <= 1'b0;
      tx_guard     <= 1'b0;
      tmo_cnt      <= '0;
      sensor_addr  <= 5'd0;
      sensor_cmd   <= 8'd0;
      tx_data      <= 8'd0;
    end else begin
      state        <= state_d;
      sensor_start <= start_d;
      tx_start     <= tx_go;
      overflow     <= push_req && full;
      tx_guard     <= tx_go;
      if (state == S_ISSUE) begin
        tmo_cnt <= '0;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + TCNT_W'(1);
      end
      if (start_d) begin
        sensor_addr <= head[12:8];
        sensor_cmd  <= head[7:0];
      end
      if (tx_go) begin
        tx_data <= tx_byte;
      end
    end
  end

  always_ff @(posedge clk_115200hz) begin
    if (pop) begin
      inf_addr <= head[12:8];
      inf_cmd  <= head[7:0];
      status   <= head[13] ? ST_INV : ST_OK;
    end
    if (cap_done) begin
      status <= sensor_error ? ST_ERR : ST_OK;
      result <= sensor_result;
    end
    if (cap_tmo) begin
      status <= ST_TMO;
    end
  end

  assign busy = !((state == S_IDLE) && (count == '0));

endmodule
